// File: rtl/mmio_slot_ctrl.sv
// MMIO slot controller: turns one bus request into one single-cycle per-slot access.
// Latency: request accepted at edge N, slot strobe in cycle N+1, rsp_valid in cycle N+2.
// Backpressure: one transaction in flight; req_ready stays low until the response is consumed.
module mmio_slot_ctrl #(
  parameter int SLOT_BITS = 4,
  parameter logic [(2**SLOT_BITS)-1:0] SLOT_EN = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [SLOT_BITS+4:0]        req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err,
  output logic [(2**SLOT_BITS)-1:0]   slot_cs,
  output logic [(2**SLOT_BITS)-1:0]   slot_read,
  output logic [(2**SLOT_BITS)-1:0]   slot_write,
  output logic [4:0]                  slot_addr,
  output logic [31:0]                 slot_wr_data,
  input  logic [32*(2**SLOT_BITS)-1:0] slot_rd_data
);

  localparam int NUM_SLOTS = 2**SLOT_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic [SLOT_BITS+4:0]  r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [SLOT_BITS-1:0]  w_idx;
  logic                  w_en;
  logic [31:0]           w_rd_sel;
  logic [NUM_SLOTS-1:0]  w_cs;
  logic [NUM_SLOTS-1:0]  w_rd;
  logic [NUM_SLOTS-1:0]  w_wr;

  // Everything slot-facing comes from the captured request, never from req_* directly.
  assign w_idx    = r_addr[SLOT_BITS+4:5];
  assign w_en     = SLOT_EN[w_idx];
  assign w_rd_sel = slot_rd_data[{w_idx, 5'd0} +: 32];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: accept in IDLE, spend exactly one ACCESS cycle, wait in RESP for the consumer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the request on acceptance; these also hold slot_addr/slot_wr_data between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && req_valid) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Register the response at the end of ACCESS; it then stays put for the whole of RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_rdata <= (w_en && !r_write) ? w_rd_sel : 32'd0;
      r_err   <= ~w_en;
    end
  end

  // One-hot strobe decode; a disabled slot gets no strobe but still costs the ACCESS cycle.
  always_comb begin
    w_cs = {NUM_SLOTS{1'b0}};
    w_rd = {NUM_SLOTS{1'b0}};
    w_wr = {NUM_SLOTS{1'b0}};
    if (r_state == ACCESS && w_en) begin
      w_cs[w_idx] = 1'b1;
      if (r_write) w_wr[w_idx] = 1'b1;
      else         w_rd[w_idx] = 1'b1;
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign rsp_valid    = (r_state == RESP);
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign slot_cs      = w_cs;
  assign slot_read    = w_rd;
  assign slot_write   = w_wr;
  assign slot_addr    = r_addr[4:0];
  assign slot_wr_data = r_wdata;

endmodule

// File: tb/tb_mmio_slot_ctrl.sv
// Directed bench for mmio_slot_ctrl with slot 3 depopulated.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task checks its own expected values inline.
module tb_mmio_slot_ctrl;

  localparam int SB = 4;
  localparam logic [15:0] SE = 16'hFFF7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [8:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [15:0]  slot_cs;
  logic [15:0]  slot_read;
  logic [15:0]  slot_write;
  logic [4:0]   slot_addr;
  logic [31:0]  slot_wr_data;
  logic [511:0] slot_rd_data = '0;

  int checks = 0;
  int failures = 0;

  mmio_slot_ctrl #(.SLOT_BITS(SB), .SLOT_EN(SE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slot_cs(slot_cs), .slot_read(slot_read), .slot_write(slot_write),
    .slot_addr(slot_addr), .slot_wr_data(slot_wr_data), .slot_rd_data(slot_rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (slot_cs !== 16'h0 || slot_read !== 16'h0 || slot_write !== 16'h0) begin failures++; $display("FAIL rst_strobes cs=%h rd=%h wr=%h exp=0", slot_cs, slot_read, slot_write); end
    checks++; if (slot_addr !== 5'h0 || slot_wr_data !== 32'h0) begin failures++; $display("FAIL rst_shared addr=%h wd=%h exp=0", slot_addr, slot_wr_data); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp v=%b d=%h e=%b exp=0", rsp_valid, rsp_rdata, rsp_err); end
    reset = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_write = 1'b1; req_addr = {4'd2, 5'h02}; req_wdata = 32'h0000_0001;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", req_ready); end
    step();
    req_valid = 1'b0;
    checks++; if (slot_cs !== 16'h0004 || slot_write !== 16'h0004 || slot_read !== 16'h0) begin failures++; $display("FAIL wr_strobe cs=%h wr=%h rd=%h exp=0004/0004/0000", slot_cs, slot_write, slot_read); end
    checks++; if (slot_addr !== 5'h02 || slot_wr_data !== 32'h1) begin failures++; $display("FAIL wr_shared addr=%h wd=%h exp=02/1", slot_addr, slot_wr_data); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL wr_access_hs v=%b rr=%b exp=0/0", rsp_valid, req_ready); end
    step();
    checks++; if (slot_cs !== 16'h0 || slot_write !== 16'h0) begin failures++; $display("FAIL wr_one_cycle cs=%h wr=%h exp=0", slot_cs, slot_write); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rsp v=%b e=%b d=%h exp=1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (slot_addr !== 5'h02 || slot_wr_data !== 32'h1) begin failures++; $display("FAIL wr_hold addr=%h wd=%h exp=02/1", slot_addr, slot_wr_data); end
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL wr_done v=%b rr=%b exp=0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_read();
    slot_rd_data[95:64] = 32'h0000_1234;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = {4'd2, 5'h00}; req_wdata = 32'h0;
    step();
    req_valid = 1'b0;
    checks++; if (slot_read !== 16'h0004 || slot_cs !== 16'h0004 || slot_write !== 16'h0) begin failures++; $display("FAIL rd_strobe rd=%h cs=%h wr=%h exp=0004/0004/0000", slot_read, slot_cs, slot_write); end
    step();
    slot_rd_data[95:64] = 32'hDEAD_BEEF;
    checks++; if (slot_read !== 16'h0) begin failures++; $display("FAIL rd_one_cycle rd=%h exp=0", slot_read); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_1234 || rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp v=%b d=%h e=%b exp=1/00001234/0", rsp_valid, rsp_rdata, rsp_err); end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_done v=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    int bad;
    slot_rd_data[63:32] = 32'h0000_CAFE;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = {4'd1, 5'h03};
    step();
    req_write = 1'b1; req_addr = {4'd4, 5'h07}; req_wdata = 32'hA5A5_0000;
    step();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_CAFE || rsp_err !== 1'b0 || req_ready !== 1'b0 ||
          slot_cs !== 16'h0 || slot_read !== 16'h0 || slot_write !== 16'h0) bad++;
      if (i < 4) step();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_stall bad_cycles=%0d exp=0 (last v=%b d=%h rr=%b cs=%h)", bad, rsp_valid, rsp_rdata, req_ready, slot_cs); end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || slot_cs !== 16'h0) begin failures++; $display("FAIL bp_idle v=%b rr=%b cs=%h exp=0/1/0", rsp_valid, req_ready, slot_cs); end
    step();
    req_valid = 1'b0;
    checks++; if (slot_cs !== 16'h0010 || slot_write !== 16'h0010 || slot_addr !== 5'h07 || slot_wr_data !== 32'hA5A5_0000) begin failures++; $display("FAIL bp_next cs=%h wr=%h a=%h wd=%h exp=0010/0010/07/a5a50000", slot_cs, slot_write, slot_addr, slot_wr_data); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL bp_next_rsp v=%b d=%h e=%b exp=1/0/0", rsp_valid, rsp_rdata, rsp_err); end
    step();
  endtask

  task automatic test_disabled();
    slot_rd_data[127:96] = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_write = 1'b0; req_addr = {4'd3, 5'h01};
    step();
    req_valid = 1'b0;
    checks++; if (slot_cs !== 16'h0 || slot_read !== 16'h0 || slot_write !== 16'h0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL dis_access cs=%h rd=%h wr=%h v=%b exp=0", slot_cs, slot_read, slot_write, rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || slot_cs !== 16'h0) begin failures++; $display("FAIL dis_rsp v=%b e=%b d=%h cs=%h exp=1/1/0/0", rsp_valid, rsp_err, rsp_rdata, slot_cs); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] slots [4];
    int strobes;
    int bad;
    slots[0] = 4'd0; slots[1] = 4'd1; slots[2] = 4'd2; slots[3] = 4'd4;
    strobes = 0; bad = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = {slots[0], 5'h00}; req_wdata = 32'd0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (slot_cs != 16'h0) strobes++;
      if (c % 3 == 0) begin
        if (slot_cs !== (16'h1 << slots[c/3]) || slot_write !== slot_cs || slot_wr_data !== 32'(c/3)) bad++;
        if (c / 3 < 3) begin
          req_addr = {slots[c/3 + 1], 5'h00};
          req_wdata = 32'(c/3 + 1);
        end else begin
          req_valid = 1'b0;
        end
      end else if (c % 3 == 1) begin
        if (rsp_valid !== 1'b1 || slot_cs !== 16'h0) bad++;
      end else begin
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || slot_cs !== 16'h0) bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_sequence bad_cycles=%0d exp=0", bad); end
    checks++; if (strobes != 4) begin failures++; $display("FAIL b2b_strobes got=%0d exp=4", strobes); end
  endtask

  task automatic test_reset_mid();
    int bad;
    req_valid = 1'b1; req_write = 1'b1; req_addr = {4'd2, 5'h04}; req_wdata = 32'h5555_AAAA;
    step();
    req_valid = 1'b0;
    checks++; if (slot_cs !== 16'h0004) begin failures++; $display("FAIL rm_access cs=%h exp=0004", slot_cs); end
    reset = 1'b1;
    step();
    checks++; if (slot_cs !== 16'h0 || slot_write !== 16'h0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_abort cs=%h wr=%h v=%b exp=0", slot_cs, slot_write, rsp_valid); end
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", req_ready); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid !== 1'b0 || slot_cs !== 16'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rm_no_rsp bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_disabled();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
